// File: rtl/pipelined_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_mul_add
// Description : Registered multiply-add, o = low_WIDTH(a*b + c), over a fixed
//               number of clock-enabled register stages. A valid bit travels
//               alongside the data through its own shift register.
//
// Parameters  : WIDTH          - width of a, b, c and o (1..18)
//               PIPELINE_DEPTH - register stages from input to output (1..4)
//
// Ports       : clk        in   rising-edge clock
//               rst        in   asynchronous active-high reset
//               ce         in   clock enable; all registers hold when 0
//               in_valid   in   qualifies a, b, c this cycle
//               a, b, c    in   unsigned operands (WIDTH bits)
//               o          out  registered result (WIDTH bits)
//               out_valid  out  o carries the result of a valid input
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_mul_add #(
    parameter int WIDTH          = 16,
    parameter int PIPELINE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] o,
    output logic             out_valid
);

    // ------------------------------------------------------------------------
    // Parameter range checks: unsupported configurations stop elaboration.
    // ------------------------------------------------------------------------
    generate
        if (PIPELINE_DEPTH < 1 || PIPELINE_DEPTH > 4) begin : g_bad_depth
            $fatal(1, "pipelined_mul_add: PIPELINE_DEPTH must be in 1..4");
        end
        if (WIDTH < 1 || WIDTH > 18) begin : g_bad_width
            $fatal(1, "pipelined_mul_add: WIDTH must be in 1..18");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Valid pipe: one bit per stage, advanced only on ce=1.
    // ------------------------------------------------------------------------
    logic [PIPELINE_DEPTH-1:0] r_vld;

    generate
        if (PIPELINE_DEPTH == 1) begin : g_vld_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                end else if (ce) begin
                    r_vld <= in_valid;
                end
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                end else if (ce) begin
                    r_vld <= {r_vld[PIPELINE_DEPTH-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign out_valid = r_vld[PIPELINE_DEPTH-1];

    // ------------------------------------------------------------------------
    // Datapath. All arithmetic is evaluated in a WIDTH-bit context: the result
    // is taken mod 2^WIDTH, and the low WIDTH bits of a sum or product depend
    // only on the low WIDTH bits of the operands, so upper product bits are
    // never formed or stored.
    //
    // Data registers load on every ce=1 cycle regardless of in_valid; o is
    // only meaningful while out_valid=1.
    // ------------------------------------------------------------------------
    generate
        if (PIPELINE_DEPTH == 1) begin : g_depth1
            // Single stage: full multiply-add straight into the output register.
            logic [WIDTH-1:0] r_o;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_o <= '0;
                end else if (ce) begin
                    r_o <= a * b + c;
                end
            end

            assign o = r_o;

        end else if (PIPELINE_DEPTH == 2) begin : g_depth2
            // Stage 1 registers the operands, stage 2 computes into o.
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_c;
            logic [WIDTH-1:0] r_o;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= '0;
                    r_o <= '0;
                end else if (ce) begin
                    r_a <= a;
                    r_b <= b;
                    r_c <= c;
                    r_o <= r_a * r_b + r_c;
                end
            end

            assign o = r_o;

        end else begin : g_depth34
            // Stage 1 registers the operands, stage 2 the product and the
            // delayed addend, stage 3 the sum. Depth 4 appends one output
            // retiming register after the sum.
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_c;
            logic [WIDTH-1:0] r_p;
            logic [WIDTH-1:0] r_c2;
            logic [WIDTH-1:0] r_s;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_c  <= '0;
                    r_p  <= '0;
                    r_c2 <= '0;
                    r_s  <= '0;
                end else if (ce) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_c  <= c;
                    r_p  <= r_a * r_b;
                    r_c2 <= r_c;
                    r_s  <= r_p + r_c2;
                end
            end

            if (PIPELINE_DEPTH == 4) begin : g_retime
                logic [WIDTH-1:0] r_out;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_out <= '0;
                    end else if (ce) begin
                        r_out <= r_s;
                    end
                end

                assign o = r_out;
            end else begin : g_no_retime
                assign o = r_s;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_mul_add
// Description : Self-checking bench for pipelined_mul_add. One instance per
//               PIPELINE_DEPTH (1..4) shares a single directed stimulus
//               stream. Each instance has a scoreboard queue filled when a
//               valid sample is captured and a monitor that checks latency,
//               data, stall stability and reset behaviour.
//
// Ports       : none
//
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipelined_mul_add;

    localparam int W = 16;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         ce       = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic [W-1:0] c        = '0;
    logic [W-1:0] exp_in   = '0;   // hand-computed expected result of a,b,c
    logic         done     = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] val;
        int           due;   // ce-edge count after which o must show val
    } exp_t;

    // ------------------------------------------------------------------------
    // One DUT + scoreboard per depth.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int D = gi + 1;

        logic [W-1:0] o;
        logic         out_valid;

        pipelined_mul_add #(
            .WIDTH          (W),
            .PIPELINE_DEPTH (D)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .in_valid  (in_valid),
            .a         (a),
            .b         (b),
            .c         (c),
            .o         (o),
            .out_valid (out_valid)
        );

        exp_t         q[$];
        exp_t         e;
        int           cnt    = 0;
        bit           adv    = 1'b0;
        bit           ev;
        logic [W-1:0] prev_o = '0;
        logic         prev_v = 1'b0;

        // Capture side: a sample captured at ce-edge n is due after edge n+D-1.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                adv = 1'b0;
            end else begin
                adv = ce;
                if (ce) begin
                    cnt++;
                    if (in_valid) q.push_back('{exp_in, cnt + D - 1});
                end
            end
        end

        // Monitor side, sampled on the falling edge.
        always @(negedge clk) begin
            if (rst) begin
                checks++;
                if (o !== '0 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_d%0d: o=%h out_valid=%b, required o=0000 out_valid=0",
                             D, o, out_valid);
                end
            end else if (adv) begin
                ev = (q.size() > 0) && (q[0].due == cnt);
                checks++;
                if (out_valid !== ev) begin
                    failures++;
                    $display("FAIL valid_d%0d: out_valid=%b at ce-edge %0d, required %b",
                             D, out_valid, cnt, ev);
                end
                if (ev) begin
                    e = q.pop_front();
                    checks++;
                    if (o !== e.val) begin
                        failures++;
                        $display("FAIL data_d%0d: o=%h at ce-edge %0d, required %h",
                                 D, o, cnt, e.val);
                    end
                end
            end else begin
                checks++;
                if (o !== prev_o || out_valid !== prev_v) begin
                    failures++;
                    $display("FAIL stall_hold_d%0d: o=%h out_valid=%b, required o=%h out_valid=%b",
                             D, o, out_valid, prev_o, prev_v);
                end
            end
            prev_o = o;
            prev_v = out_valid;
        end

        // Every sample issued must have come out by the end of the run.
        always @(posedge done) begin
            checks++;
            if (q.size() != 0) begin
                failures++;
                $display("FAIL drain_d%0d: pending=%0d, required 0", D, q.size());
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic drive(input logic v, input logic e,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input logic [W-1:0] iexp);
        in_valid = v;
        ce       = e;
        a        = ia;
        b        = ib;
        c        = ic;
        exp_in   = iexp;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles carry junk data so data registers keep changing under
    // out_valid=0.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 16'hAAAA, 16'h5555, 16'h1234, 16'h0000);
    endtask

    initial begin
        // Reset held, first with ce=0 then with ce=1 and in_valid=1: reset wins.
        repeat (3) @(posedge clk);
        #1;
        ce       = 1'b1;
        in_valid = 1'b1;
        a        = 16'd9;
        b        = 16'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single sample: 3*5+7 = 22
        drive(1'b1, 1'b1, 16'd3, 16'd5, 16'd7, 16'd22);
        idle(6);

        // Back-to-back stream: 1, 10, 101
        drive(1'b1, 1'b1, 16'd1,  16'd1,  16'd0, 16'd1);
        drive(1'b1, 1'b1, 16'd2,  16'd3,  16'd4, 16'd10);
        drive(1'b1, 1'b1, 16'd10, 16'd10, 16'd1, 16'd101);
        idle(6);

        // Stall: 4*4+4 = 20, then ce=0 for 3 cycles with in_valid=1 (ignored)
        drive(1'b1, 1'b1, 16'd4, 16'd4, 16'd4, 16'd20);
        repeat (3) drive(1'b1, 1'b0, 16'd7, 16'd7, 16'd7, 16'd0);
        idle(6);

        // Stall with several samples in flight: 37, 72, 10100 (0x2774)
        drive(1'b1, 1'b1, 16'd5,   16'd6,   16'd7,   16'd37);
        drive(1'b1, 1'b1, 16'd8,   16'd8,   16'd8,   16'd72);
        drive(1'b0, 1'b0, 16'd1,   16'd1,   16'd1,   16'd0);
        drive(1'b1, 1'b0, 16'd2,   16'd2,   16'd2,   16'd0);
        drive(1'b1, 1'b1, 16'd100, 16'd100, 16'd100, 16'h2774);
        idle(6);

        // Wrap-around
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
        drive(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0005, 16'h0005);
        idle(6);

        // Invalid gap: valid pattern 1,0,1 -> results 4 and 9
        drive(1'b1, 1'b1, 16'd2, 16'd2, 16'd0, 16'd4);
        drive(1'b0, 1'b1, 16'd9, 16'd9, 16'd9, 16'd0);
        drive(1'b1, 1'b1, 16'd3, 16'd3, 16'd0, 16'd9);
        idle(6);

        // Asynchronous reset mid-flight: two samples issued, then rst rises
        // between edges; everything in flight is discarded.
        drive(1'b1, 1'b1, 16'd11, 16'd2, 16'd3, 16'd25);
        drive(1'b1, 1'b1, 16'd6,  16'd6, 16'd6, 16'd42);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);

        // Final sample after reset to confirm normal operation resumes: 7*7+1 = 50
        drive(1'b1, 1'b1, 16'd7, 16'd7, 16'd1, 16'd50);
        idle(6);

        done = 1'b1;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
